// File: rtl/microcode_sequencer.sv
// microcode_sequencer: loadable microcode store plus a fetch/execute sequencer.
// A control word is selected by {opcode, latched flags, micro-step}. Every
// instruction costs one FETCH cycle followed by 1..2**STEP_W EXEC cycles.
// Optional feature macro: MCSEQ_TRAP_EN. When it is defined, each store word
// carries a valid bit and executing an unwritten word traps into HALT.
module microcode_sequencer #(
  parameter int                OP_W       = 4,
  parameter int                FLAG_W     = 2,
  parameter int                STEP_W     = 2,
  parameter int                CW_W       = 13,
  parameter logic [CW_W-1:0]   FETCH_WORD = 13'h1008
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [OP_W-1:0]                  opcode,
  input  logic [FLAG_W-1:0]                flags,
  input  logic                             wr_en,
  input  logic [OP_W+FLAG_W+STEP_W-1:0]    wr_addr,
  input  logic [CW_W:0]                    wr_data,
  output logic [CW_W-1:0]                  ctrl,
  output logic                             fetch,
  output logic [STEP_W-1:0]                step,
  output logic                             trap
);

  localparam int                AW       = OP_W + FLAG_W + STEP_W;
  localparam int                DEPTH    = 1 << AW;
  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t              state_q, state_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic [OP_W-1:0]     op_q, op_n;
  logic [FLAG_W-1:0]   fl_q, fl_n;

  // Bit CW_W of each word is END; contents survive reset, zero at power-up.
  logic [CW_W:0]       store [DEPTH] = '{default: '0};
  logic [AW-1:0]       rd_addr;
  logic [CW_W:0]       rd_word;
  logic                rd_end;
  logic                rd_valid;

  assign rd_addr = {op_q, fl_q, step_q};
  assign rd_word = store[rd_addr];
  assign rd_end  = rd_word[CW_W];

  // Store write port; reset takes priority so a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) store[wr_addr] <= wr_data;
  end

`ifdef MCSEQ_TRAP_EN
  logic [DEPTH-1:0] valid_q;
  logic             trap_q, trap_n;

  // Valid bits: cleared by reset, set by any write to that word.
  always_ff @(posedge clk) begin
    if (reset)      valid_q <= '0;
    else if (wr_en) valid_q[wr_addr] <= 1'b1;
  end

  assign rd_valid = valid_q[rd_addr];
  assign trap     = trap_q;
`else
  assign rd_valid = 1'b1;
  assign trap     = 1'b0;
`endif

  // State register: sequencer state, micro-step and the latched instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      step_q  <= '0;
      op_q    <= '0;
      fl_q    <= '0;
`ifdef MCSEQ_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      op_q    <= op_n;
      fl_q    <= fl_n;
`ifdef MCSEQ_TRAP_EN
      trap_q  <= trap_n;
`endif
    end
  end

  // Next-state logic; en=0 holds everything except the HALT state, which
  // has no way out but reset anyway.
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    op_n    = op_q;
    fl_n    = fl_q;
`ifdef MCSEQ_TRAP_EN
    trap_n  = trap_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (en) begin
          // Flags are captured here once and held for the whole instruction.
          state_n = S_EXEC;
          op_n    = opcode;
          fl_n    = flags;
          step_n  = '0;
        end
      end
      S_EXEC: begin
        if (en) begin
`ifdef MCSEQ_TRAP_EN
          if (!rd_valid) begin
            state_n = S_HALT;
            trap_n  = 1'b1;
          end else
`endif
          if (rd_end || step_q == STEP_MAX) begin
            // Running off the last step is legal and simply ends the instruction.
            state_n = S_FETCH;
            step_n  = '0;
          end else begin
            step_n  = step_q + 1'b1;
          end
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Output decode from registered state; an invalid word reads as zero.
  always_comb begin
    ctrl  = '0;
    fetch = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl  = FETCH_WORD;
        fetch = 1'b1;
      end
      S_EXEC:  ctrl = rd_valid ? rd_word[CW_W-1:0] : '0;
      default: ctrl = '0;
    endcase
  end

  assign step = step_q;

endmodule
